// File: rtl/rv_pkg.sv
// rv_pkg: RV32I opcodes, ALU encodings and control-field decode shared by the decode stage
package rv_pkg;

   localparam int XLEN = 32;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD  = 4'd0;
   localparam logic [3:0] ALU_SUB  = 4'd1;
   localparam logic [3:0] ALU_SLL  = 4'd2;
   localparam logic [3:0] ALU_SLT  = 4'd3;
   localparam logic [3:0] ALU_SLTU = 4'd4;
   localparam logic [3:0] ALU_XOR  = 4'd5;
   localparam logic [3:0] ALU_OR   = 4'd6;
   localparam logic [3:0] ALU_AND  = 4'd7;
   localparam logic [3:0] ALU_SRL  = 4'd8;
   localparam logic [3:0] ALU_SRA  = 4'd9;

   typedef struct packed {
      logic [3:0] alu_op;
      logic       alu_src;
      logic       reg_wen;
      logic       mem_read;
      logic       mem_write;
      logic       branch;
      logic       jump;
      logic       illegal;
   } ctl_t;

   // funct3 selects the operation; bit 30 picks SUB (register form only) or SRA
   function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt, input logic reg_op);
      case (f3)
         3'd0:    return (alt && reg_op) ? ALU_SUB : ALU_ADD;
         3'd1:    return ALU_SLL;
         3'd2:    return ALU_SLT;
         3'd3:    return ALU_SLTU;
         3'd4:    return ALU_XOR;
         3'd5:    return alt ? ALU_SRA : ALU_SRL;
         3'd6:    return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic logic uses_rs1(input logic [6:0] op);
      return op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
   endfunction

   function automatic logic uses_rs2(input logic [6:0] op);
      return op inside {OP_R, OP_STORE, OP_BRANCH};
   endfunction

   // Unknown opcodes leave every side-effecting control bit clear and raise illegal
   function automatic ctl_t decode_ctl(input logic [31:0] instr);
      ctl_t c;
      logic [6:0] op;
      op          = instr[6:0];
      c           = '0;
      c.reg_wen   = op inside {OP_R, OP_I, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
      c.alu_src   = op inside {OP_I, OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC};
      c.mem_read  = op == OP_LOAD;
      c.mem_write = op == OP_STORE;
      c.branch    = op == OP_BRANCH;
      c.jump      = op inside {OP_JAL, OP_JALR};
      c.illegal   = !(op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC});
      c.alu_op    = (op == OP_R || op == OP_I) ? alu_decode(instr[14:12], instr[30], op == OP_R) :
                    (op == OP_BRANCH) ? ALU_SUB : ALU_ADD;
      return c;
   endfunction

endpackage

// File: rtl/imm_gen.sv
// imm_gen: sign-extended RV32I immediate selected by opcode format
module imm_gen
   import rv_pkg::*;
(
   input  logic [31:0] instr,
   output logic [31:0] imm
);

   // Reassemble the scattered immediate bits for each instruction format
   always_comb begin
      imm = '0;
      case (instr[6:0])
         OP_I, OP_LOAD, OP_JALR: imm = {{20{instr[31]}}, instr[31:20]};
         OP_STORE:               imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         OP_BRANCH:              imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         OP_LUI, OP_AUIPC:       imm = {instr[31:12], 12'b0};
         OP_JAL:                 imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default:                imm = '0;
      endcase
   end

endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32I IF/ID register, operand read with writeback bypass, load-use stall, ID/EX bundle
module decode_stage #(
   parameter int XLEN = 32,
   parameter int AW   = 5
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   output logic [AW-1:0]   rr1,
   output logic [AW-1:0]   rr2,
   input  logic [XLEN-1:0] rd1,
   input  logic [XLEN-1:0] rd2,
   input  logic            wb_wen,
   input  logic [AW-1:0]   wb_wr,
   input  logic [XLEN-1:0] wb_wd,
   output logic            ex_valid,
   input  logic            ex_ready,
   output logic [XLEN-1:0] ex_pc,
   output logic [XLEN-1:0] ex_op_a,
   output logic [XLEN-1:0] ex_op_b,
   output logic [XLEN-1:0] ex_imm,
   output logic [AW-1:0]   ex_rd,
   output logic [3:0]      ex_alu_op,
   output logic            ex_alu_src,
   output logic            ex_reg_wen,
   output logic            ex_mem_read,
   output logic            ex_mem_write,
   output logic            ex_branch,
   output logic            ex_jump,
   output logic            ex_illegal
);
   import rv_pkg::*;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] op_a;
      logic [XLEN-1:0] op_b;
      logic [XLEN-1:0] imm;
      logic [AW-1:0]   rd;
      ctl_t            ctl;
   } bundle_t;

   logic            id_valid;
   logic [31:0]     id_instr;
   logic [XLEN-1:0] id_pc;
   logic [AW-1:0]   rs1;
   logic [AW-1:0]   rs2;
   logic [31:0]     imm;
   logic            use1;
   logic            use2;
   logic            ex_free;
   logic            hazard;
   logic            id_adv;
   bundle_t         ex_q;
   bundle_t         ex_d;

   assign rs1  = id_instr[19:15];
   assign rs2  = id_instr[24:20];
   assign rr1  = rs1;
   assign rr2  = rs2;
   assign use1 = uses_rs1(id_instr[6:0]);
   assign use2 = uses_rs2(id_instr[6:0]);

   imm_gen u_imm (
      .instr (id_instr),
      .imm   (imm)
   );

   // A load in EX whose rd feeds a source this instruction reads must wait one slot
   assign ex_free  = !ex_valid || ex_ready;
   assign hazard   = ex_valid && ex_q.ctl.mem_read && ex_q.rd != '0 &&
                     ((use1 && ex_q.rd == rs1) || (use2 && ex_q.rd == rs2));
   assign id_adv   = id_valid && !hazard && ex_free;
   assign if_ready = !id_valid || id_adv;

   // Build the next bundle: x0 reads as zero, then the in-flight writeback wins over the register file
   always_comb begin
      ex_d      = '0;
      ex_d.pc   = id_pc;
      ex_d.op_a = (rs1 == '0) ? '0 : (wb_wen && wb_wr == rs1) ? wb_wd : rd1;
      ex_d.op_b = (rs2 == '0) ? '0 : (wb_wen && wb_wr == rs2) ? wb_wd : rd2;
      ex_d.imm  = XLEN'($signed(imm));
      ex_d.rd   = id_instr[11:7];
      ex_d.ctl  = decode_ctl(id_instr);
   end

   // IF/ID register: capture on the fetch handshake, empty when the instruction moves on
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_valid <= 1'b0;
         id_instr <= '0;
         id_pc    <= '0;
      end else if (flush) begin
         id_valid <= 1'b0;
      end else if (if_valid && if_ready) begin
         id_valid <= 1'b1;
         id_instr <= if_instr;
         id_pc    <= if_pc;
      end else if (id_adv) begin
         id_valid <= 1'b0;
      end
   end

   // ID/EX register: refill with the decoded bundle or a bubble only when execute can take it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ex_valid <= 1'b0;
         ex_q     <= '0;
      end else if (flush) begin
         ex_valid <= 1'b0;
         ex_q     <= '0;
      end else if (ex_free) begin
         ex_valid <= id_adv;
         ex_q     <= id_adv ? ex_d : '0;
      end
   end

   assign ex_pc        = ex_q.pc;
   assign ex_op_a      = ex_q.op_a;
   assign ex_op_b      = ex_q.op_b;
   assign ex_imm       = ex_q.imm;
   assign ex_rd        = ex_q.rd;
   assign ex_alu_op    = ex_q.ctl.alu_op;
   assign ex_alu_src   = ex_q.ctl.alu_src;
   assign ex_reg_wen   = ex_q.ctl.reg_wen;
   assign ex_mem_read  = ex_q.ctl.mem_read;
   assign ex_mem_write = ex_q.ctl.mem_write;
   assign ex_branch    = ex_q.ctl.branch;
   assign ex_jump      = ex_q.ctl.jump;
   assign ex_illegal   = ex_q.ctl.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random checks of decode_stage against a transaction-level model
module tb_decode_stage;
   import rv_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        flush = 1'b0;
   logic        if_valid = 1'b0;
   logic        ex_ready = 1'b0;
   logic        wb_wen = 1'b0;
   logic [31:0] if_instr = '0;
   logic [31:0] if_pc = '0;
   logic [31:0] wb_wd = '0;
   logic [4:0]  wb_wr = '0;
   logic        if_ready, ex_valid, ex_alu_src, ex_reg_wen, ex_mem_read, ex_mem_write;
   logic        ex_branch, ex_jump, ex_illegal;
   logic [4:0]  rr1, rr2, ex_rd;
   logic [3:0]  ex_alu_op;
   logic [31:0] rd1, rd2, ex_pc, ex_op_a, ex_op_b, ex_imm;
   logic [31:0] regs [32];

   int n_chk = 0;
   int n_fail = 0;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] imm;
      logic [4:0]  rd;
      logic [10:0] ctl;
   } bun_t;

   logic        m_idv, m_exv;
   logic [31:0] m_idi, m_idpc;
   bun_t        m_ex;

   always #5 clk = ~clk;

   decode_stage dut (
      .clk(clk), .rst(rst), .flush(flush),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
      .rr1(rr1), .rr2(rr2), .rd1(rd1), .rd2(rd2),
      .wb_wen(wb_wen), .wb_wr(wb_wr), .wb_wd(wb_wd),
      .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_pc(ex_pc), .ex_op_a(ex_op_a),
      .ex_op_b(ex_op_b), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op),
      .ex_alu_src(ex_alu_src), .ex_reg_wen(ex_reg_wen), .ex_mem_read(ex_mem_read),
      .ex_mem_write(ex_mem_write), .ex_branch(ex_branch), .ex_jump(ex_jump),
      .ex_illegal(ex_illegal)
   );

   // Register file without internal forwarding; x0 reads back garbage to prove the DUT zeroes it
   assign rd1 = (rr1 == 5'd0) ? 32'hDEAD_BEEF : regs[rr1];
   assign rd2 = (rr2 == 5'd0) ? 32'hBAAD_F00D : regs[rr2];
   always @(posedge clk) if (wb_wen && wb_wr != 5'd0) regs[wb_wr] <= wb_wd;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic u1(input logic [31:0] i);
      return i[6:0] inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR};
   endfunction

   function automatic logic u2(input logic [31:0] i);
      return i[6:0] inside {OP_R, OP_STORE, OP_BRANCH};
   endfunction

   function automatic logic [31:0] opv(input logic [4:0] r);
      if (r == 5'd0) return 32'd0;
      if (wb_wen && wb_wr == r) return wb_wd;
      return regs[r];
   endfunction

   // Expected bundle straight from the instruction-set tables
   function automatic bun_t dec(input logic [31:0] i, input logic [31:0] pc);
      bun_t x;
      int v;
      logic [11:0] s12;
      logic [12:0] b13;
      logic [20:0] j21;
      logic [6:0] op;
      logic [3:0] alu;
      logic [3:0] tab [8];
      tab = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
      op = i[6:0];
      v = 0;
      alu = ALU_ADD;
      if (op == OP_R || op == OP_I) begin
         alu = tab[i[14:12]];
         if (i[14:12] == 3'd5 && i[30]) alu = ALU_SRA;
         if (i[14:12] == 3'd0 && i[30] && op == OP_R) alu = ALU_SUB;
      end
      if (op == OP_BRANCH) alu = ALU_SUB;
      case (op)
         OP_I, OP_LOAD, OP_JALR: begin s12 = i[31:20]; v = $signed(s12); end
         OP_STORE:  begin s12 = {i[31:25], i[11:7]}; v = $signed(s12); end
         OP_BRANCH: begin b13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; v = $signed(b13); end
         OP_LUI, OP_AUIPC: v = int'(i[31:12]) * 4096;
         OP_JAL:    begin j21 = {i[31], i[19:12], i[20], i[30:21], 1'b0}; v = $signed(j21); end
         default:   v = 0;
      endcase
      x.pc  = pc;
      x.a   = opv(i[19:15]);
      x.b   = opv(i[24:20]);
      x.imm = v;
      x.rd  = i[11:7];
      x.ctl = {alu,
               1'(op inside {OP_I, OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC}),
               1'(op inside {OP_R, OP_I, OP_LOAD, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC}),
               1'(op == OP_LOAD), 1'(op == OP_STORE), 1'(op == OP_BRANCH),
               1'(op inside {OP_JAL, OP_JALR}),
               1'(!(op inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC}))};
      return x;
   endfunction

   task automatic mreset();
      m_idv = 1'b0;
      m_exv = 1'b0;
      m_idi = '0;
      m_idpc = '0;
      m_ex = '0;
   endtask

   // One clock: drive inputs, compare DUT with the model, then advance the model across the edge
   task automatic cyc(input logic iv, input logic [31:0] ins, input logic [31:0] pc, input logic er,
                      input logic fl, input logic we, input logic [4:0] wr, input logic [31:0] wd);
      logic hz, adv, rdy;
      bun_t nb;
      @(negedge clk);
      if_valid = iv; if_instr = ins; if_pc = pc; ex_ready = er; flush = fl;
      wb_wen = we; wb_wr = wr; wb_wd = wd;
      #1;
      hz  = m_exv && m_ex.ctl[4] && m_ex.rd != 5'd0 &&
            ((u1(m_idi) && m_ex.rd == m_idi[19:15]) || (u2(m_idi) && m_ex.rd == m_idi[24:20]));
      adv = m_idv && !hz && (!m_exv || er);
      rdy = !m_idv || adv;
      check("if_ready", 32'(if_ready), 32'(rdy));
      check("ex_valid", 32'(ex_valid), 32'(m_exv));
      check("rr1", 32'(rr1), 32'(m_idi[19:15]));
      check("rr2", 32'(rr2), 32'(m_idi[24:20]));
      check("ctl", 32'({ex_alu_op, ex_alu_src, ex_reg_wen, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_illegal}),
            32'(m_ex.ctl));
      if (m_exv) begin
         check("ex_pc", ex_pc, m_ex.pc);
         check("ex_op_a", ex_op_a, m_ex.a);
         check("ex_op_b", ex_op_b, m_ex.b);
         check("ex_imm", ex_imm, m_ex.imm);
         check("ex_rd", 32'(ex_rd), 32'(m_ex.rd));
      end
      nb = dec(m_idi, m_idpc);
      if (fl) begin
         m_idv = 1'b0;
         m_exv = 1'b0;
         m_ex = '0;
      end else begin
         if (!m_exv || er) begin
            m_exv = adv;
            m_ex = adv ? nb : '0;
         end
         if (iv && rdy) begin
            m_idv = 1'b1;
            m_idi = ins;
            m_idpc = pc;
         end else if (adv) begin
            m_idv = 1'b0;
         end
      end
   endtask

   task automatic idle(input int n);
      repeat (n) cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
   endtask

   function automatic logic [31:0] rand_instr();
      logic [31:0] i;
      logic [6:0] ops [10];
      ops = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, 7'h7F};
      i = $urandom;
      i[6:0] = ops[$urandom_range(0, 9)];
      i[11:7] = 5'($urandom_range(0, 7));
      i[19:15] = 5'($urandom_range(0, 7));
      i[24:20] = 5'($urandom_range(0, 7));
      return i;
   endfunction

   initial begin
      mreset();
      @(negedge clk);
      check("rst_ex_valid", 32'(ex_valid), 32'd0);
      check("rst_if_ready", 32'(if_ready), 32'd1);
      check("rst_ex_pc", ex_pc, 32'd0);
      check("rst_ctl", 32'({ex_alu_op, ex_alu_src, ex_reg_wen, ex_mem_read, ex_mem_write, ex_branch, ex_jump, ex_illegal}), 32'd0);
      rst = 1'b0;

      // addi x1,x0,10
      cyc(1'b1, 32'h00A0_0093, 32'h100, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      idle(1);
      check("addi_rr1", 32'(rr1), 32'd0);
      idle(1);
      check("addi_valid", 32'(ex_valid), 32'd1);
      check("addi_imm", ex_imm, 32'd10);
      check("addi_rd", 32'(ex_rd), 32'd1);
      check("addi_src", 32'(ex_alu_src), 32'd1);
      check("addi_wen", 32'(ex_reg_wen), 32'd1);
      check("addi_op_a", ex_op_a, 32'd0);

      // x1=0xA, x2=0xB then add x3,x1,x2
      cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd1, 32'hA);
      cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd2, 32'hB);
      cyc(1'b1, 32'h0020_81B3, 32'h104, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      idle(1);
      check("add_rr1", 32'(rr1), 32'd1);
      check("add_rr2", 32'(rr2), 32'd2);
      idle(1);
      check("add_op_a", ex_op_a, 32'hA);
      check("add_op_b", ex_op_b, 32'hB);

      // same-cycle writeback to x1 is bypassed
      cyc(1'b1, 32'h0020_81B3, 32'h108, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd1, 32'h55);
      idle(1);
      check("byp_op_a", ex_op_a, 32'h55);
      check("byp_op_b", ex_op_b, 32'hB);
      cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd1, 32'hA);
      cyc(1'b1, 32'h0020_81B3, 32'h10C, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      cyc(1'b0, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1, 5'd0, 32'h55);
      idle(1);
      check("nobyp_op_a", ex_op_a, 32'hA);

      // lw x5,0(x1) then add x6,x5,x5: one bubble
      cyc(1'b1, 32'h0000_A283, 32'h110, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      cyc(1'b1, 32'h0052_8333, 32'h114, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      idle(1);
      check("lu_if_ready", 32'(if_ready), 32'd0);
      check("lu_load", 32'(ex_mem_read), 32'd1);
      idle(1);
      check("lu_bubble", 32'(ex_valid), 32'd0);
      idle(1);
      check("lu_add_valid", 32'(ex_valid), 32'd1);
      check("lu_add_rd", 32'(ex_rd), 32'd6);

      // execute back-pressure, then flush
      cyc(1'b1, 32'h00A0_0093, 32'h200, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      cyc(1'b1, 32'h0020_81B3, 32'h204, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      repeat (3) cyc(1'b1, 32'h00A0_0093, 32'h208, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      check("stall_pc", ex_pc, 32'h200);
      check("stall_imm", ex_imm, 32'd10);
      check("stall_if_ready", 32'(if_ready), 32'd0);
      cyc(1'b1, 32'h00A0_0093, 32'h20C, 1'b0, 1'b1, 1'b0, 5'd0, 32'd0);
      idle(1);
      check("flush_ex_valid", 32'(ex_valid), 32'd0);
      check("flush_if_ready", 32'(if_ready), 32'd1);

      // illegal opcode and beq x1,x2,-4
      cyc(1'b1, 32'h0000_037F, 32'h300, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      idle(2);
      check("ill_valid", 32'(ex_valid), 32'd1);
      check("ill_flag", 32'(ex_illegal), 32'd1);
      check("ill_wen", 32'(ex_reg_wen), 32'd0);
      cyc(1'b1, 32'hFE20_8EE3, 32'h304, 1'b1, 1'b0, 1'b0, 5'd0, 32'd0);
      idle(2);
      check("beq_imm", ex_imm, 32'hFFFF_FFFC);
      check("beq_branch", 32'(ex_branch), 32'd1);

      // reset in the middle of a load-use stall
      cyc(1'b1, 32'h0000_A283, 32'h400, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      cyc(1'b1, 32'h0052_8333, 32'h404, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0);
      #1 rst = 1'b1;
      #1;
      check("mrst_ex_valid", 32'(ex_valid), 32'd0);
      check("mrst_if_ready", 32'(if_ready), 32'd1);
      check("mrst_load", 32'(ex_mem_read), 32'd0);
      check("mrst_pc", ex_pc, 32'd0);
      mreset();
      @(negedge clk);
      rst = 1'b0;

      // random traffic
      repeat (3000)
         cyc(1'($urandom_range(0, 3) != 0), rand_instr(), $urandom, 1'($urandom_range(0, 3) != 0),
             1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
